// File: rtl/multi_port_mem_bus.sv
// Shared word RAM behind an N-port round-robin bus.
// One transaction in flight; one done pulse per request.
module multi_port_mem_bus #(
  parameter int NPORTS = 2,
  parameter int WW     = 16,
  parameter int AW     = 16,
  parameter int DEPTH  = 256,
  parameter int LAT    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2*NPORTS-1:0]        rwFromCache,
  input  logic [AW*NPORTS-1:0]       addrFromCache,
  input  logic [WW*NPORTS-1:0]       dataFromCache,
  output logic [WW*NPORTS-1:0]       dataToCache,
  output logic [NPORTS-1:0]          rdEnToCache,
  output logic [NPORTS-1:0]          wbDoneToCache,
  output logic                       busy,
  output logic [$clog2(NPORTS)-1:0]  grantIdx
);

  localparam int PW = $clog2(NPORTS);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [WW-1:0]   wdata_q, wdata_d;
  logic [WW-1:0]   rdata_q [NPORTS];
  logic [WW-1:0]   rdata_d [NPORTS];

  logic [WW-1:0]   mem [DEPTH];
  logic            mem_we;
  logic [IW-1:0]   idx;

  logic [1:0]      rw_a   [NPORTS];
  logic [AW-1:0]   addr_a [NPORTS];
  logic [WW-1:0]   data_a [NPORTS];
  logic [NPORTS-1:0] req;
  logic            found;
  logic [PW:0]     ksum;
  logic [PW-1:0]   k;

  // Upper address bits only alias onto the same word.
  logic            unused_addr;
  assign unused_addr = ^addr_q;
  assign idx = addr_q[IW-1:0];

  always_comb begin
    req = '0;
    for (int p = 0; p < NPORTS; p++) begin
      rw_a[p]   = rwFromCache[2*p +: 2];
      addr_a[p] = addrFromCache[p*AW +: AW];
      data_a[p] = dataFromCache[p*WW +: WW];
      req[p]    = (rw_a[p] == 2'b01) ||
                  (rw_a[p] == 2'b10);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    found   = 1'b0;
    ksum    = '0;
    k       = '0;
    unique case (state_q)
      IDLE: begin
        for (int i = 0; i < NPORTS; i++) begin
          ksum = {1'b0, rr_q} + (PW+1)'(i);
          if (ksum >= (PW+1)'(NPORTS))
            ksum = ksum - (PW+1)'(NPORTS);
          k = ksum[PW-1:0];
          if (!found && req[k]) begin
            found   = 1'b1;
            gnt_d   = k;
            wr_d    = rw_a[k][1];
            addr_d  = addr_a[k];
            wdata_d = data_a[k];
          end
        end
        if (found) begin
          state_d = ACCESS;
          cnt_d   = CW'(LAT - 1);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (wr_q) mem_we = 1'b1;
          else rdata_d[gnt_q] = mem[idx];
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        rr_d = (gnt_q == PW'(NPORTS - 1)) ?
               '0 : gnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      rr_q    <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      for (int p = 0; p < NPORTS; p++)
        rdata_q[p] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // A reset on the commit edge drops the pending write.
  always_ff @(posedge clk) begin
    if (reset && mem_we)
      mem[idx] <= wdata_q;
  end

  always_comb begin
    rdEnToCache   = '0;
    wbDoneToCache = '0;
    if (state_q == RESP) begin
      if (wr_q) wbDoneToCache[gnt_q] = 1'b1;
      else      rdEnToCache[gnt_q]   = 1'b1;
    end
  end

  always_comb begin
    dataToCache = '0;
    for (int p = 0; p < NPORTS; p++)
      dataToCache[p*WW +: WW] = rdata_q[p];
  end

  assign busy     = (state_q != IDLE);
  assign grantIdx = gnt_q;

endmodule

// File: tb/tb_multi_port_mem_bus.sv
// Directed bench for multi_port_mem_bus.
// Two 4-port instances: LAT=2 and LAT=1.
module tb_multi_port_mem_bus;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0]  rw0, rw1;
  logic [63:0] a0, a1, wd0, wd1, do0, do1;
  logic [3:0]  rd0, rd1, wb0, wb1;
  logic        bz0, bz1;
  logic [1:0]  g0, g1;

  int nvec = 0;
  int nerr = 0;

  multi_port_mem_bus #(
    .NPORTS(4), .WW(16), .AW(16),
    .DEPTH(256), .LAT(2)
  ) u_dut (
    .clk(clk), .reset(reset),
    .rwFromCache(rw0),
    .addrFromCache(a0),
    .dataFromCache(wd0),
    .dataToCache(do0),
    .rdEnToCache(rd0),
    .wbDoneToCache(wb0),
    .busy(bz0), .grantIdx(g0)
  );

  multi_port_mem_bus #(
    .NPORTS(4), .WW(16), .AW(16),
    .DEPTH(256), .LAT(1)
  ) u_lat1 (
    .clk(clk), .reset(reset),
    .rwFromCache(rw1),
    .addrFromCache(a1),
    .dataFromCache(wd1),
    .dataToCache(do1),
    .rdEnToCache(rd1),
    .wbDoneToCache(wb1),
    .busy(bz1), .grantIdx(g1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(
    input bit sel, input int p,
    input logic [1:0] rwv,
    input logic [15:0] a,
    input logic [15:0] d);
    if (!sel) begin
      rw0[2*p +: 2] = rwv;
      a0[16*p +: 16] = a;
      wd0[16*p +: 16] = d;
    end else begin
      rw1[2*p +: 2] = rwv;
      a1[16*p +: 16] = a;
      wd1[16*p +: 16] = d;
    end
  endtask

  task automatic drop(input bit sel, input int p);
    if (!sel) rw0[2*p +: 2] = 2'b00;
    else      rw1[2*p +: 2] = 2'b00;
  endtask

  // Advance until a pulse appears; cyc=-1 on timeout.
  task automatic wait_pulse(
    input bit sel, output int cyc,
    output logic [3:0] rdv,
    output logic [3:0] wbv,
    output logic [63:0] dv);
    bit done;
    done = 1'b0;
    cyc = -1; rdv = '0; wbv = '0; dv = '0;
    for (int i = 1; i <= 12; i++) begin
      if (!done) begin
        tick();
        if (!sel && (rd0 | wb0) != 4'b0) begin
          done = 1'b1;
          cyc = i; rdv = rd0; wbv = wb0; dv = do0;
        end
        if (sel && (rd1 | wb1) != 4'b0) begin
          done = 1'b1;
          cyc = i; rdv = rd1; wbv = wb1; dv = do1;
        end
      end
    end
  endtask

  task automatic preload(
    input bit sel, input int p,
    input logic [15:0] a,
    input logic [15:0] d);
    int c;
    logic [3:0] r, w;
    logic [63:0] dv;
    set_port(sel, p, 2'b10, a, d);
    wait_pulse(sel, c, r, w, dv);
    nvec++;
    if (c < 0 || w !== 4'(1 << p)) begin
      nerr++;
      $display("FAIL preload a=%h cyc=%0d wb=%b", a, c, w);
    end
    drop(sel, p);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_port(0, 0, 2'b01, 16'h0, 16'h0);
    set_port(1, 0, 2'b01, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++;
      if (rd0 !== 4'b0 || wb0 !== 4'b0 ||
          bz0 !== 1'b0 || g0 !== 2'd0 ||
          do0 !== 64'h0) begin
        nerr++;
        $display("FAIL reset c%0d rd=%b wb=%b bz=%b g=%0d do=%h want 0",
                 i, rd0, wb0, bz0, g0, do0);
      end
      nvec++;
      if (rd1 !== 4'b0 || wb1 !== 4'b0 ||
          bz1 !== 1'b0 || do1 !== 64'h0) begin
        nerr++;
        $display("FAIL reset_lat1 c%0d rd=%b wb=%b bz=%b want 0",
                 i, rd1, wb1, bz1);
      end
    end
    drop(0, 0);
    drop(1, 0);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    int c;
    logic [3:0] r, w;
    logic [63:0] dv;
    set_port(0, 0, 2'b10, 16'h0000, 16'h0003);
    tick();
    nvec++;
    if (bz0 !== 1'b1 || g0 !== 2'd0 || wb0 !== 4'b0) begin
      nerr++;
      $display("FAIL wr_c1 bz=%b g=%0d wb=%b want 1/0/0000",
               bz0, g0, wb0);
    end
    tick();
    nvec++;
    if (wb0 !== 4'b0 || bz0 !== 1'b1) begin
      nerr++;
      $display("FAIL wr_c2 wb=%b bz=%b want 0000/1", wb0, bz0);
    end
    tick();
    nvec++;
    if (wb0 !== 4'b0001 || rd0 !== 4'b0) begin
      nerr++;
      $display("FAIL wr_c3 wb=%b rd=%b want 0001/0000", wb0, rd0);
    end
    drop(0, 0);
    tick();
    nvec++;
    if (bz0 !== 1'b0 || wb0 !== 4'b0) begin
      nerr++;
      $display("FAIL wr_c4 bz=%b wb=%b want 0/0000", bz0, wb0);
    end
    set_port(0, 1, 2'b01, 16'h0000, 16'h0);
    wait_pulse(0, c, r, w, dv);
    nvec++;
    if (c != 3 || r !== 4'b0010 || w !== 4'b0 ||
        dv[31:16] !== 16'h0003 || g0 !== 2'd1) begin
      nerr++;
      $display("FAIL rd_p1 cyc=%0d rd=%b wb=%b d=%h g=%0d want 3/0010/0000/0003/1",
               c, r, w, dv[31:16], g0);
    end
    drop(0, 1);
    tick();
    nvec++;
    if (rd0 !== 4'b0 || do0[31:16] !== 16'h0003) begin
      nerr++;
      $display("FAIL rd_hold rd=%b d=%h want 0000/0003",
               rd0, do0[31:16]);
    end
  endtask

  task automatic test_contention();
    int c;
    int e;
    logic [3:0] r, w;
    logic [63:0] dv;
    int ord [2][4] = '{'{0, 1, 2, 3}, '{2, 3, 0, 1}};
    logic [15:0] exp_d [4] =
      '{16'h0003, 16'h0011, 16'h0022, 16'h0033};
    preload(0, 0, 16'h1, 16'h0011);
    preload(0, 0, 16'h2, 16'h0022);
    preload(0, 0, 16'h3, 16'h0033);
    do_reset();
    for (int rnd = 0; rnd < 2; rnd++) begin
      if (rnd == 1) begin
        set_port(0, 1, 2'b01, 16'h1, 16'h0);
        wait_pulse(0, c, r, w, dv);
        drop(0, 1);
        tick();
      end
      for (int p = 0; p < 4; p++)
        set_port(0, p, 2'b01, 16'(p), 16'h0);
      for (int g = 0; g < 4; g++) begin
        e = ord[rnd][g];
        wait_pulse(0, c, r, w, dv);
        nvec++;
        if (c != ((g == 0) ? 3 : 4) ||
            r !== 4'(1 << e) || g0 !== 2'(e) ||
            dv[16*e +: 16] !== exp_d[e]) begin
          nerr++;
          $display("FAIL rr%0d_%0d cyc=%0d rd=%b g=%0d d=%h want port %0d d=%h",
                   rnd, g, c, r, g0, dv[16*e +: 16], e, exp_d[e]);
        end
        drop(0, e);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    int c;
    logic [3:0] r, w;
    logic [63:0] dv;
    set_port(0, 3, 2'b10, 16'h0105, 16'hA5A5);
    wait_pulse(0, c, r, w, dv);
    nvec++;
    if (c != 3 || w !== 4'b1000) begin
      nerr++;
      $display("FAIL wrap_wr cyc=%0d wb=%b want 3/1000", c, w);
    end
    drop(0, 3);
    tick();
    set_port(0, 1, 2'b01, 16'h0005, 16'h0);
    wait_pulse(0, c, r, w, dv);
    nvec++;
    if (r !== 4'b0010 || dv[31:16] !== 16'hA5A5) begin
      nerr++;
      $display("FAIL wrap_rd rd=%b d=%h want 0010/a5a5",
               r, dv[31:16]);
    end
    drop(0, 1);
    tick();
  endtask

  task automatic test_reset_mid();
    int c;
    logic [3:0] r, w;
    logic [63:0] dv;
    preload(0, 0, 16'h7, 16'h0BEE);
    set_port(0, 0, 2'b10, 16'h7, 16'h1234);
    tick();
    tick();
    reset = 1'b0;
    drop(0, 0);
    tick();
    nvec++;
    if (bz0 !== 1'b0 || wb0 !== 4'b0 || rd0 !== 4'b0) begin
      nerr++;
      $display("FAIL abort bz=%b wb=%b rd=%b want 0", bz0, wb0, rd0);
    end
    reset = 1'b1;
    tick();
    nvec++;
    if (bz0 !== 1'b0 || wb0 !== 4'b0) begin
      nerr++;
      $display("FAIL abort_post bz=%b wb=%b want 0", bz0, wb0);
    end
    set_port(0, 2, 2'b01, 16'h7, 16'h0);
    wait_pulse(0, c, r, w, dv);
    nvec++;
    if (c != 3 || r !== 4'b0100 || w !== 4'b0 ||
        dv[47:32] !== 16'h0BEE) begin
      nerr++;
      $display("FAIL abort_rd cyc=%0d rd=%b wb=%b d=%h want 3/0100/0000/0bee",
               c, r, w, dv[47:32]);
    end
    drop(0, 2);
    tick();
  endtask

  task automatic test_latch();
    int c;
    logic [3:0] r, w;
    logic [63:0] dv;
    set_port(1, 0, 2'b10, 16'h4, 16'h4444);
    wait_pulse(1, c, r, w, dv);
    nvec++;
    if (c != 2 || w !== 4'b0001) begin
      nerr++;
      $display("FAIL lat1_wr cyc=%0d wb=%b want 2/0001", c, w);
    end
    drop(1, 0);
    tick();
    preload(1, 0, 16'h9, 16'h9999);
    set_port(1, 2, 2'b01, 16'h4, 16'h0);
    tick();
    set_port(1, 2, 2'b01, 16'h9, 16'h0);
    tick();
    nvec++;
    if (rd1 !== 4'b0100 || do1[47:32] !== 16'h4444) begin
      nerr++;
      $display("FAIL latch rd=%b d=%h want 0100/4444",
               rd1, do1[47:32]);
    end
    drop(1, 2);
    tick();
  endtask

  task automatic test_back_to_back();
    int c;
    logic [3:0] r, w;
    logic [63:0] dv;
    set_port(0, 1, 2'b11, 16'h0, 16'h0);
    set_port(0, 0, 2'b01, 16'h0, 16'h0);
    for (int n = 0; n < 2; n++) begin
      wait_pulse(0, c, r, w, dv);
      nvec++;
      if (c != ((n == 0) ? 3 : 4) || r !== 4'b0001 ||
          g0 !== 2'd0 || dv[15:0] !== 16'h0003) begin
        nerr++;
        $display("FAIL b2b%0d cyc=%0d rd=%b g=%0d d=%h want port0 d=0003",
                 n, c, r, g0, dv[15:0]);
      end
    end
    drop(0, 0);
    drop(0, 1);
    tick();
    tick();
    nvec++;
    if (bz0 !== 1'b0 || rd0 !== 4'b0) begin
      nerr++;
      $display("FAIL b2b_idle bz=%b rd=%b want 0/0000", bz0, rd0);
    end
  endtask

  initial begin
    reset = 1'b0;
    rw0 = '0; a0 = '0; wd0 = '0;
    rw1 = '0; a1 = '0; wd1 = '0;
    test_reset();
    test_write_read();
    test_contention();
    test_wrap();
    test_reset_mid();
    test_latch();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
